// File: rtl/small_level_meter.sv
// small_level_meter
//   Measures peak and mean magnitude of a signed sample stream over windows of
//   2^WIN_SHIFT enabled samples, and raises a sticky alarm on large samples.
//
// Ports
//   clk      system clock, all state updates on the rising edge
//   rst      synchronous active-high reset
//   en       dataIn carries a valid sample this cycle
//   clear    synchronous window restart and alarm clear
//   dataIn   signed sample, WIDTH bits
//   peakOut  max |sample| of the last completed window
//   meanOut  mean |sample| of the last completed window (truncated)
//   valid    one-cycle strobe: peakOut/meanOut just updated
//   alarm    sticky: some |sample| >= THRESH since the last clear or reset
module small_level_meter #(
   parameter int WIDTH     = 16,
   parameter int WIN_SHIFT = 10,
   parameter int THRESH    = 2 ** (WIDTH - 2)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    clear,
   input  logic signed [WIDTH-1:0] dataIn,
   output logic        [WIDTH-1:0] peakOut,
   output logic        [WIDTH-1:0] meanOut,
   output logic                    valid,
   output logic                    alarm
);

   localparam int MAG_W = WIDTH - 1;
   localparam int ACC_W = MAG_W + WIN_SHIFT;
   localparam logic [MAG_W-1:0] THRESH_M = MAG_W'(THRESH);

   logic [WIN_SHIFT-1:0] cnt_q, cnt_d;
   logic [MAG_W-1:0]     pk_q, pk_d;
   logic [ACC_W-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]     peak_q, peak_d;
   logic [WIDTH-1:0]     mean_q, mean_d;
   logic                 valid_q, valid_d;
   logic                 alarm_q, alarm_d;

   logic [WIDTH-1:0]     neg_w;
   logic [MAG_W-1:0]     mag;
   logic [MAG_W-1:0]     pk_max;
   logic [ACC_W-1:0]     acc_sum;
   logic                 win_final;

   // |dataIn|; the most negative code has no positive twin, so it saturates.
   always_comb begin
      neg_w = $unsigned(~dataIn) + WIDTH'(1);
      if (dataIn[WIDTH-1]) begin
         mag = neg_w[WIDTH-1] ? {MAG_W{1'b1}} : neg_w[MAG_W-1:0];
      end else begin
         mag = dataIn[MAG_W-1:0];
      end
   end

   always_comb begin
      pk_max    = (mag > pk_q) ? mag : pk_q;
      acc_sum   = acc_q + ACC_W'(mag);
      win_final = &cnt_q;

      cnt_d   = cnt_q;
      pk_d    = pk_q;
      acc_d   = acc_q;
      peak_d  = peak_q;
      mean_d  = mean_q;
      valid_d = 1'b0;
      alarm_d = alarm_q;

      if (clear) begin
         // clear wins over a pending sample, including a window-final one
         cnt_d   = '0;
         pk_d    = '0;
         acc_d   = '0;
         alarm_d = 1'b0;
      end else if (en) begin
         if (mag >= THRESH_M) begin
            alarm_d = 1'b1;
         end
         if (win_final) begin
            peak_d  = {1'b0, pk_max};
            mean_d  = {1'b0, acc_sum[ACC_W-1:WIN_SHIFT]};
            valid_d = 1'b1;
            cnt_d   = '0;
            pk_d    = '0;
            acc_d   = '0;
         end else begin
            cnt_d = cnt_q + WIN_SHIFT'(1);
            pk_d  = pk_max;
            acc_d = acc_sum;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         pk_q    <= '0;
         acc_q   <= '0;
         peak_q  <= '0;
         mean_q  <= '0;
         valid_q <= 1'b0;
         alarm_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pk_q    <= pk_d;
         acc_q   <= acc_d;
         peak_q  <= peak_d;
         mean_q  <= mean_d;
         valid_q <= valid_d;
         alarm_q <= alarm_d;
      end
   end

   assign peakOut = peak_q;
   assign meanOut = mean_q;
   assign valid   = valid_q;
   assign alarm   = alarm_q;

endmodule

// File: tb/tb_small_level_meter.sv
module tb_small_level_meter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // directed instance: short window
   logic               rst_a = 1'b1, clr_a = 1'b0, en_a = 1'b0;
   logic signed [15:0] d_a = '0;
   logic        [15:0] pk_a, mn_a;
   logic               v_a, al_a;

   small_level_meter #(.WIDTH(16), .WIN_SHIFT(2), .THRESH(1000)) dut_a (
      .clk(clk), .rst(rst_a), .en(en_a), .clear(clr_a), .dataIn(d_a),
      .peakOut(pk_a), .meanOut(mn_a), .valid(v_a), .alarm(al_a)
   );

   // random instance: full-size window, default threshold
   logic               rst_b = 1'b1, clr_b = 1'b0, en_b = 1'b0;
   logic signed [15:0] d_b = '0;
   logic        [15:0] pk_b, mn_b;
   logic               v_b, al_b;

   small_level_meter #(.WIDTH(16), .WIN_SHIFT(10), .THRESH(16384)) dut_b (
      .clk(clk), .rst(rst_b), .en(en_b), .clear(clr_b), .dataIn(d_b),
      .peakOut(pk_b), .meanOut(mn_b), .valid(v_b), .alarm(al_b)
   );

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic               rst;
      logic               clr;
      logic               en;
      logic signed [15:0] d;
      logic               v;
      logic        [15:0] pk;
      logic        [15:0] mn;
      logic               al;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic c, input logic e, input int d,
                      input logic v, input int pk, input int mn, input logic al);
      vec_t x;
      x.rst = r; x.clr = c; x.en = e; x.d = 16'(d);
      x.v = v; x.pk = 16'(pk); x.mn = 16'(mn); x.al = al;
      tbl.push_back(x);
   endtask

   // enabled sample; idle cycle
   task automatic s(input int d, input logic v, input int pk, input int mn, input logic al);
      add(1'b0, 1'b0, 1'b1, d, v, pk, mn, al);
   endtask
   task automatic idle(input int pk, input int mn, input logic al);
      add(1'b0, 1'b0, 1'b0, 0, 1'b0, pk, mn, al);
   endtask

   task automatic run_directed();
      // reset
      add(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0);
      // basic window: sum 1000 -> mean 250
      s(100, 0, 0, 0, 0); s(-200, 0, 0, 0, 0); s(300, 0, 0, 0, 0);
      s(-400, 1, 400, 250, 0);
      idle(400, 250, 0);
      // most negative code saturates
      s(-32768, 0, 400, 250, 1); s(-32768, 0, 400, 250, 1); s(-32768, 0, 400, 250, 1);
      s(-32768, 1, 32767, 32767, 1);
      add(1'b0, 1'b1, 1'b0, 0, 1'b0, 32767, 32767, 1'b0);
      // gaps in en do not split the window
      for (int k = 0; k < 3; k++) begin
         s(8, 0, 32767, 32767, 0);
         for (int g = 0; g < 3; g++) idle(32767, 32767, 0);
      end
      s(9, 1, 9, 8, 0);
      idle(9, 8, 0);
      // clear mid-window discards its own sample and the partial window
      s(500, 0, 9, 8, 0); s(500, 0, 9, 8, 0);
      add(1'b0, 1'b1, 1'b1, 2000, 1'b0, 9, 8, 1'b0);
      s(40, 0, 9, 8, 0); s(40, 0, 9, 8, 0); s(40, 0, 9, 8, 0);
      s(40, 1, 40, 40, 0);
      // reset mid-window beats en
      s(1200, 0, 40, 40, 1); s(1200, 0, 40, 40, 1); s(1200, 0, 40, 40, 1);
      add(1'b1, 1'b0, 1'b1, 1200, 1'b0, 0, 0, 1'b0);
      s(7, 0, 0, 0, 0); s(7, 0, 0, 0, 0); s(7, 0, 0, 0, 0);
      s(7, 1, 7, 7, 0);
      // back-to-back windows, no dead cycle
      s(1, 0, 7, 7, 0); s(2, 0, 7, 7, 0); s(3, 0, 7, 7, 0);
      s(4, 1, 4, 2, 0);
      s(8, 0, 4, 2, 0); s(8, 0, 4, 2, 0); s(8, 0, 4, 2, 0);
      s(8, 1, 8, 8, 0);
      // clear on what would be the window-final edge wins
      s(5, 0, 8, 8, 0); s(5, 0, 8, 8, 0); s(5, 0, 8, 8, 0);
      add(1'b0, 1'b1, 1'b1, 5, 1'b0, 8, 8, 1'b0);
      s(6, 0, 8, 8, 0); s(6, 0, 8, 8, 0); s(6, 0, 8, 8, 0);
      s(6, 1, 6, 6, 0);
      // threshold boundary: 999 no alarm, 1000 alarm
      s(999, 0, 6, 6, 0); s(1000, 0, 6, 6, 1); s(-1000, 0, 6, 6, 1);
      s(1, 1, 1000, 750, 1);
      idle(1000, 750, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst_a = tbl[i].rst; clr_a = tbl[i].clr; en_a = tbl[i].en; d_a = tbl[i].d;
         @(posedge clk);
         #1;
         n_vec++;
         if (v_a !== tbl[i].v || pk_a !== tbl[i].pk || mn_a !== tbl[i].mn || al_a !== tbl[i].al) begin
            n_err++;
            $display("FAIL vec%0d: got valid=%0b peak=%0d mean=%0d alarm=%0b, exp valid=%0b peak=%0d mean=%0d alarm=%0b",
                     i, v_a, pk_a, mn_a, al_a, tbl[i].v, tbl[i].pk, tbl[i].mn, tbl[i].al);
         end
      end
      @(negedge clk);
      en_a = 1'b0; clr_a = 1'b0; rst_a = 1'b0;
   endtask

   function automatic int absmag(input logic signed [15:0] d);
      if (d == -16'sd32768) return 32767;
      return (d < 0) ? -int'(d) : int'(d);
   endfunction

   task automatic run_random();
      int     m_cnt = 0, m_pk = 0, m_sum = 0, n_en = 0, n_win = 0;
      int     e_pk = 0, e_mn = 0, shamt = 0, m;
      logic   e_v, e_al = 1'b0;
      logic signed [15:0] raw;
      @(negedge clk); @(negedge clk);
      rst_b = 1'b0;
      while (n_en < 65536) begin
         @(negedge clk);
         e_v  = 1'b0;
         en_b = ($urandom_range(0, 15) != 0);
         if (m_cnt == 0) shamt = $urandom_range(0, 15);
         raw  = 16'($urandom);
         d_b  = ($urandom_range(0, 999) == 0) ? -16'sd32768 : (raw >>> shamt);
         if (en_b) begin
            n_en++;
            m = absmag(d_b);
            if (m >= 16384) e_al = 1'b1;
            if (m > m_pk) m_pk = m;
            m_sum += m;
            if (m_cnt == 1023) begin
               e_v = 1'b1; e_pk = m_pk; e_mn = m_sum / 1024;
               m_cnt = 0; m_pk = 0; m_sum = 0;
               n_win++;
            end else begin
               m_cnt++;
            end
         end
         @(posedge clk);
         #1;
         if (v_b !== e_v) begin
            n_vec++; n_err++;
            $display("FAIL rand valid timing at enabled sample %0d: got %0b exp %0b", n_en, v_b, e_v);
         end
         if (e_v) begin
            n_vec++;
            if (pk_b !== 16'(e_pk) || mn_b !== 16'(e_mn) || al_b !== e_al) begin
               n_err++;
               $display("FAIL rand window %0d: got peak=%0d mean=%0d alarm=%0b, exp peak=%0d mean=%0d alarm=%0b",
                        n_win, pk_b, mn_b, al_b, e_pk, e_mn, e_al);
            end
         end
      end
      @(negedge clk);
      en_b = 1'b0;
      @(posedge clk);
      #1;
      n_vec++;
      if (n_win != 64 || pk_b !== 16'(e_pk) || mn_b !== 16'(e_mn)) begin
         n_err++;
         $display("FAIL rand final: windows=%0d peak=%0d mean=%0d, exp windows=64 peak=%0d mean=%0d",
                  n_win, pk_b, mn_b, e_pk, e_mn);
      end
   endtask

   initial begin
      fork
         run_directed();
         run_random();
      join
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/small_level_meter.md
SMALL_LEVEL_METER -- requirements
Module: small_level_meter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the signed input sample width.
REQ-002 The block SHALL have parameter WIN_SHIFT, default 10, meaning a window of 2^WIN_SHIFT enabled samples.
REQ-003 The block SHALL have parameter THRESH, default 2^(WIDTH-2), meaning the alarm magnitude threshold (unsigned, 1 to 2^(WIDTH-1)-1).
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the system clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, meaning reset, synchronous and active-high.
REQ-006 The block SHALL have port en, input, 1 bit, meaning dataIn holds a valid sample this cycle.
REQ-007 The block SHALL have port clear, input, 1 bit, meaning synchronous window restart and alarm clear.
REQ-008 The block SHALL have port dataIn, input, WIDTH bits signed, meaning the sample under measurement, typically a filter output.
REQ-009 The block SHALL have port peakOut, output, WIDTH bits unsigned, meaning the maximum |sample| of the last completed window.
REQ-010 The block SHALL have port meanOut, output, WIDTH bits unsigned, meaning the mean |sample| of the last completed window.
REQ-011 The block SHALL have port valid, output, 1 bit, meaning a one-cycle strobe that peakOut/meanOut were updated.
REQ-012 The block SHALL have port alarm, output, 1 bit, meaning a sticky flag that some |sample| >= THRESH since the last clear or reset.

Function
REQ-013 The block SHALL form mag = |dataIn| combinationally; dataIn = -2^(WIDTH-1) SHALL saturate to 2^(WIDTH-1)-1.
REQ-014 The block SHALL keep sample counter cnt (WIN_SHIFT bits), peak register pk (WIDTH-1 bits), and unsigned sum accumulator acc (WIDTH-1+WIN_SHIFT bits, no overflow possible).
REQ-015 The block SHALL, on an edge with en=1, clear=0, and cnt < 2^WIN_SHIFT-1: increment cnt, set pk to max(pk, mag), and set acc to acc+mag.
REQ-016 The block SHALL, on an edge with en=1, clear=0, and cnt = 2^WIN_SHIFT-1 (window-final sample): load peakOut with max(pk, mag), load meanOut with (acc+mag) >> WIN_SHIFT (truncating, zero-extended to WIDTH), set valid=1, and reset cnt, pk and acc to 0.
REQ-017 The block SHALL hold valid high for exactly the one cycle following the window-final edge, and low at all other times.
REQ-018 The block SHALL, on an edge with en=0, leave cnt, pk, acc, peakOut, meanOut and alarm unchanged and drive valid=0; gaps in en SHALL NOT shorten or split a window.
REQ-019 The block SHALL hold peakOut and meanOut between windows.
REQ-020 The block SHALL set alarm on an edge with en=1, clear=0 and mag >= THRESH; alarm SHALL then stay high until clear or rst.
REQ-021 The block SHALL, on an edge with clear=1: reset cnt, pk and acc to 0; drive alarm=0 and valid=0; discard the sample even if en=1; leave peakOut and meanOut unchanged.
REQ-022 The block SHALL give clear priority over en and over a window-final event on the same edge.
REQ-023 The block SHALL give a sample arriving one cycle after a window-final sample cnt=0 in the new window, with no dead cycle.

Reset
REQ-024 The block SHALL, on rst=1 at a clock edge, reset cnt, pk, acc, peakOut, meanOut, valid and alarm to 0.
REQ-025 The block SHALL give rst priority over clear and en; a mid-window reset SHALL discard the partial window, and the first enabled sample after rst deasserts SHALL be sample 0 of a new window.

Verification (WIDTH=16, WIN_SHIFT=2, THRESH=1000 unless noted)
REQ-026 The bench SHALL apply en=1 with dataIn 100, -200, 300, -400 on consecutive edges and check peakOut=400, meanOut=250, valid high for exactly one cycle after the 4th edge.
REQ-027 The bench SHALL apply four samples of -32768 and check peakOut=32767, meanOut=32767, alarm=1.
REQ-028 The bench SHALL apply samples 8, 8, 8, 9 with en low for 3 cycles between each and check a single valid, peakOut=9, meanOut=8 (33>>2), and outputs held during the gaps.
REQ-029 The bench SHALL apply 2 samples of 500, then clear=1 with en=1 and dataIn=2000, then 4 samples of 40, and check alarm=0, the next valid gives peakOut=40, meanOut=40, and the earlier window outputs are unchanged before that valid.
REQ-030 The bench SHALL apply 3 samples of 1200 (alarm=1), then rst for 1 cycle, then 4 samples of 7, and check all outputs 0 after reset and then peakOut=7, meanOut=7, alarm=0.
REQ-031 The bench SHALL, with WIN_SHIFT=10, apply 2^16 random samples with en toggled randomly and check peakOut, meanOut and valid timing against a reference model for every window.
